// File: rtl/noc_local_ejector.sv
// noc_pkg: flit format shared by the local injector and ejector.
//   A flit carries a 2-bit label, a VC id and a flit_Size data word. On
//   HEAD/HEADTAIL flits the data word is a head_Data header (x, y, payload).
package noc_pkg;

  localparam int x_Des_Addr_Size = 4;
  localparam int y_Des_Addr_Size = 4;
  localparam int flit_Size       = 32;
  localparam int vc_Num          = 4;
  localparam int VC_Size         = 2;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  // Destination fields sit in the MSBs of the data word.
  typedef struct packed {
    logic [x_Des_Addr_Size-1:0]                           x_Dest;
    logic [y_Des_Addr_Size-1:0]                           y_Dest;
    logic [flit_Size-x_Des_Addr_Size-y_Des_Addr_Size-1:0] payload;
  } head_Data;

  typedef struct packed {
    flit_label_t          label;
    logic [VC_Size-1:0]   vc_Id;
    logic [flit_Size-1:0] data;
  } flit_Data_withvc;

endpackage

// noc_local_ejector: receive side of the local router port.
//   Checks per-VC packet framing and header destination; good packets go to
//   the core as a sop/eop-tagged stream through one output register, bad
//   flits are dropped with a one-cycle error pulse.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flit_i/flit_valid_i      incoming flit and its valid
//   flit_ready_o             accept strobe to the router (combinational)
//   out_data_o/out_vc_o      output word and its VC
//   out_sop_o/out_eop_o      packet first/last word markers
//   out_trunc_o              on sop: previous packet on this VC was cut short
//   out_valid_o/out_ready_i  output handshake
//   err_proto_o/err_route_o  framing / misroute error pulses
//   pkt_cnt_o                count of delivered packets (counted on eop accept)
// Latency 1 (accept -> out_valid_o). Full throughput while out_ready_i is high;
// flit_ready_o drops only when the output register is full and stalled.
module noc_local_ejector
  import noc_pkg::*;
#(
  parameter logic [x_Des_Addr_Size-1:0] MY_X   = '0,
  parameter logic [y_Des_Addr_Size-1:0] MY_Y   = '0,
  parameter int                         VC_NUM = vc_Num,
  parameter int                         CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  flit_Data_withvc      flit_i,
  input  logic                 flit_valid_i,
  output logic                 flit_ready_o,
  output logic [flit_Size-1:0] out_data_o,
  output logic [VC_Size-1:0]   out_vc_o,
  output logic                 out_sop_o,
  output logic                 out_eop_o,
  output logic                 out_trunc_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 err_proto_o,
  output logic                 err_route_o,
  output logic [CNT_W-1:0]     pkt_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DROP   = 2'b10
  } vc_state_e;

  // Per-VC framing state
  vc_state_e st_q [VC_NUM];
  vc_state_e st_d [VC_NUM];

  // Output register
  logic                 out_valid_q, out_valid_d;
  logic [flit_Size-1:0] out_data_q,  out_data_d;
  logic [VC_Size-1:0]   out_vc_q,    out_vc_d;
  logic                 out_sop_q,   out_sop_d;
  logic                 out_eop_q,   out_eop_d;
  logic                 out_trunc_q, out_trunc_d;

  logic                 err_proto_q, err_proto_d;
  logic                 err_route_q, err_route_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;

  // Decode of the flit currently presented
  logic                 accept;
  logic                 dest_match;
  vc_state_e            cur_st, nxt_st;
  logic                 emit, f_sop, f_eop, f_trunc;
  logic                 f_proto, f_route, f_cnt;

  assign flit_ready_o = !out_valid_q || out_ready_i;
  assign accept       = flit_valid_i && flit_ready_o;

  // Header destination lives in the top bits of the data word (head_Data layout).
  assign dest_match =
      (flit_i.data[flit_Size-1 -: x_Des_Addr_Size] == MY_X) &&
      (flit_i.data[flit_Size-1-x_Des_Addr_Size -: y_Des_Addr_Size] == MY_Y);

  // Per-flit decision against the addressed VC's state
  always_comb begin
    cur_st  = st_q[flit_i.vc_Id];
    nxt_st  = cur_st;
    emit    = 1'b0;
    f_sop   = 1'b0;
    f_eop   = 1'b0;
    f_trunc = 1'b0;
    f_proto = 1'b0;
    f_route = 1'b0;
    f_cnt   = 1'b0;

    case (flit_i.label)
      HEAD, HEADTAIL: begin
        // A head always restarts framing; arriving mid-packet is a
        // framing error, and an open (delivered) packet is marked truncated.
        f_proto = (cur_st != ST_IDLE);
        if (dest_match) begin
          emit    = 1'b1;
          f_sop   = 1'b1;
          f_trunc = (cur_st == ST_ACTIVE);
          if (flit_i.label == HEADTAIL) begin
            f_eop  = 1'b1;
            f_cnt  = 1'b1;
            nxt_st = ST_IDLE;
          end else begin
            nxt_st = ST_ACTIVE;
          end
        end else begin
          f_route = 1'b1;
          nxt_st  = (flit_i.label == HEAD) ? ST_DROP : ST_IDLE;
        end
      end

      BODY: begin
        case (cur_st)
          ST_ACTIVE: emit    = 1'b1;
          ST_DROP:   emit    = 1'b0;
          default:   f_proto = 1'b1;
        endcase
      end

      default: begin // TAIL
        case (cur_st)
          ST_ACTIVE: begin
            emit   = 1'b1;
            f_eop  = 1'b1;
            f_cnt  = 1'b1;
            nxt_st = ST_IDLE;
          end
          ST_DROP:   nxt_st  = ST_IDLE;
          default:   f_proto = 1'b1;
        endcase
      end
    endcase
  end

  // Next-state for the VC table, output register, errors and counter
  always_comb begin
    st_d = st_q;
    if (accept) begin
      st_d[flit_i.vc_Id] = nxt_st;
    end

    // Unload on handshake; a new word may load in the same cycle.
    out_valid_d = out_valid_q && !out_ready_i;
    out_data_d  = out_data_q;
    out_vc_d    = out_vc_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_trunc_d = out_trunc_q;
    if (accept && emit) begin
      out_valid_d = 1'b1;
      out_data_d  = flit_i.data;
      out_vc_d    = flit_i.vc_Id;
      out_sop_d   = f_sop;
      out_eop_d   = f_eop;
      out_trunc_d = f_trunc;
    end

    err_proto_d = accept && f_proto;
    err_route_d = accept && f_route;

    cnt_d = cnt_q;
    if (accept && f_cnt) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VC_NUM; i++) begin
        st_q[i] <= ST_IDLE;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_vc_q    <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_trunc_q <= 1'b0;
      err_proto_q <= 1'b0;
      err_route_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      st_q        <= st_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_vc_q    <= out_vc_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_trunc_q <= out_trunc_d;
      err_proto_q <= err_proto_d;
      err_route_q <= err_route_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_vc_o    = out_vc_q;
  assign out_sop_o   = out_sop_q;
  assign out_eop_o   = out_eop_q;
  assign out_trunc_o = out_trunc_q;
  assign err_proto_o = err_proto_q;
  assign err_route_o = err_route_q;
  assign pkt_cnt_o   = cnt_q;

endmodule

// File: tb/tb_noc_local_ejector.sv
module tb_noc_local_ejector;
  import noc_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  flit_Data_withvc flit;
  logic            flit_valid;
  logic            flit_ready;
  logic [31:0]     out_data;
  logic [1:0]      out_vc;
  logic            out_sop, out_eop, out_trunc, out_valid, out_ready;
  logic            err_proto, err_route;
  logic [15:0]     pkt_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_local_ejector #(
    .MY_X   (4'd2),
    .MY_Y   (4'd3),
    .VC_NUM (4),
    .CNT_W  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flit_i       (flit),
    .flit_valid_i (flit_valid),
    .flit_ready_o (flit_ready),
    .out_data_o   (out_data),
    .out_vc_o     (out_vc),
    .out_sop_o    (out_sop),
    .out_eop_o    (out_eop),
    .out_trunc_o  (out_trunc),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .err_proto_o  (err_proto),
    .err_route_o  (err_route),
    .pkt_cnt_o    (pkt_cnt)
  );

  typedef struct {
    logic        v;
    flit_label_t lab;
    logic [1:0]  vc;
    logic [31:0] dat;
    logic        rdy;
    logic        frdy;   // expected flit_ready_o before the edge
    logic        ov, sop, eop, tr;
    logic [1:0]  ovc;
    logic [31:0] odat;
    logic        ep, er;
    logic [15:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] H(input logic [3:0] x, input logic [3:0] y,
                                    input logic [23:0] p);
    head_Data h;
    h.x_Dest  = x;
    h.y_Dest  = y;
    h.payload = p;
    return h;
  endfunction

  // Output word fields other than errors/count matter only while valid.
  function automatic logic [55:0] pk(input logic ov, input logic sop, input logic eop,
                                     input logic tr, input logic [1:0] vc,
                                     input logic [31:0] d, input logic ep,
                                     input logic er, input logic [15:0] c, input logic m);
    if (m) return {ov, sop, eop, tr, vc, d, ep, er, c};
    return {ov, 3'b000, 2'b00, 32'h0, ep, er, c};
  endfunction

  task automatic chk(input string nm, input logic [55:0] act, input logic [55:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input flit_label_t lab, input logic [1:0] vc,
                     input logic [31:0] dat, input logic rdy, input logic frdy,
                     input logic ov, input logic sop, input logic eop, input logic tr,
                     input logic [1:0] ovc, input logic [31:0] odat,
                     input logic ep, input logic er, input logic [15:0] cnt);
    vec_t t;
    t.v = v; t.lab = lab; t.vc = vc; t.dat = dat; t.rdy = rdy; t.frdy = frdy;
    t.ov = ov; t.sop = sop; t.eop = eop; t.tr = tr; t.ovc = ovc; t.odat = odat;
    t.ep = ep; t.er = er; t.cnt = cnt;
    vq.push_back(t);
  endtask

  // Called just after a falling edge: drive, check ready, clock, check outputs.
  task automatic step(input vec_t t, input string nm);
    flit_valid = t.v;
    flit.label = t.lab;
    flit.vc_Id = t.vc;
    flit.data  = t.dat;
    out_ready  = t.rdy;
    #1;
    chk({nm, "_frdy"}, {55'd0, flit_ready}, {55'd0, t.frdy});
    @(posedge clk);
    #1;
    chk({nm, "_out"},
        pk(out_valid, out_sop, out_eop, out_trunc, out_vc, out_data, err_proto, err_route,
           pkt_cnt, t.ov),
        pk(t.ov, t.sop, t.eop, t.tr, t.ovc, t.odat, t.ep, t.er, t.cnt, t.ov));
    @(negedge clk);
  endtask

  initial begin
    vec_t t;
    rst        = 1'b1;
    flit_valid = 1'b0;
    flit       = '0;
    out_ready  = 1'b1;

    // ---- directed vector table (MY = 2,3) ----
    // single packet vc1
    add(1, HEAD,     1, H(2,3,24'hBEEF), 1, 1, 1,1,0,0, 1, H(2,3,24'hBEEF), 0,0, 0);
    add(1, BODY,     1, 32'h1111_1111,   1, 1, 1,0,0,0, 1, 32'h1111_1111,   0,0, 0);
    add(1, TAIL,     1, 32'h2222_2222,   1, 1, 1,0,1,0, 1, 32'h2222_2222,   0,0, 1);
    add(0, BODY,     0, 32'h0,           1, 1, 0,0,0,0, 0, 32'h0,           0,0, 1);
    // misrouted headtail, then stray body
    add(1, HEADTAIL, 0, H(1,3,24'hA),    1, 1, 0,0,0,0, 0, 32'h0,           0,1, 1);
    add(1, BODY,     0, 32'h3333_3333,   1, 1, 0,0,0,0, 0, 32'h0,           1,0, 1);
    add(0, BODY,     0, 32'h0,           1, 1, 0,0,0,0, 0, 32'h0,           0,0, 1);
    // misrouted packet vc2 dropped whole, then good headtail
    add(1, HEAD,     2, H(2,4,24'h1),    1, 1, 0,0,0,0, 0, 32'h0,           0,1, 1);
    add(1, BODY,     2, 32'h0000_00B1,   1, 1, 0,0,0,0, 0, 32'h0,           0,0, 1);
    add(1, BODY,     2, 32'h0000_00B2,   1, 1, 0,0,0,0, 0, 32'h0,           0,0, 1);
    add(1, TAIL,     2, 32'h0000_00B3,   1, 1, 0,0,0,0, 0, 32'h0,           0,0, 1);
    add(1, HEADTAIL, 2, H(2,3,24'h77),   1, 1, 1,1,1,0, 2, H(2,3,24'h77),   0,0, 2);
    add(0, BODY,     0, 32'h0,           1, 1, 0,0,0,0, 0, 32'h0,           0,0, 2);
    // head in ACTIVE: truncation
    add(1, HEAD,     0, H(2,3,24'h100),  1, 1, 1,1,0,0, 0, H(2,3,24'h100),  0,0, 2);
    add(1, BODY,     0, 32'h4444_4444,   1, 1, 1,0,0,0, 0, 32'h4444_4444,   0,0, 2);
    add(1, HEAD,     0, H(2,3,24'h200),  1, 1, 1,1,0,1, 0, H(2,3,24'h200),  1,0, 2);
    add(1, TAIL,     0, 32'h5555_5555,   1, 1, 1,0,1,0, 0, 32'h5555_5555,   0,0, 3);
    add(0, BODY,     0, 32'h0,           1, 1, 0,0,0,0, 0, 32'h0,           0,0, 3);
    // misrouted head while ACTIVE: both errors, VC returns to IDLE
    add(1, HEAD,     3, H(2,3,24'h300),  1, 1, 1,1,0,0, 3, H(2,3,24'h300),  0,0, 3);
    add(1, HEADTAIL, 3, H(5,5,24'h1),    1, 1, 0,0,0,0, 0, 32'h0,           1,1, 3);
    add(1, BODY,     3, 32'h0000_0007,   1, 1, 0,0,0,0, 0, 32'h0,           1,0, 3);
    // head while DROP: proto error, delivered without trunc
    add(1, HEAD,     1, H(0,0,24'h0),    1, 1, 0,0,0,0, 0, 32'h0,           0,1, 3);
    add(1, HEAD,     1, H(2,3,24'h9),    1, 1, 1,1,0,0, 1, H(2,3,24'h9),    1,0, 3);
    add(1, TAIL,     1, 32'h6666_6666,   1, 1, 1,0,1,0, 1, 32'h6666_6666,   0,0, 4);
    add(0, BODY,     0, 32'h0,           1, 1, 0,0,0,0, 0, 32'h0,           0,0, 4);
    // interleaved vc0/vc3 with a 5-cycle output stall
    add(1, HEAD,     0, H(2,3,24'hA0),   1, 1, 1,1,0,0, 0, H(2,3,24'hA0),   0,0, 4);
    for (int i = 0; i < 5; i++)
      add(1, HEAD,   3, H(2,3,24'hB0),   0, 0, 1,1,0,0, 0, H(2,3,24'hA0),   0,0, 4);
    add(1, HEAD,     3, H(2,3,24'hB0),   1, 1, 1,1,0,0, 3, H(2,3,24'hB0),   0,0, 4);
    add(1, BODY,     0, 32'h0000_00A1,   1, 1, 1,0,0,0, 0, 32'h0000_00A1,   0,0, 4);
    add(1, TAIL,     3, 32'h0000_00B2,   1, 1, 1,0,1,0, 3, 32'h0000_00B2,   0,0, 5);
    add(1, TAIL,     0, 32'h0000_00A2,   1, 1, 1,0,1,0, 0, 32'h0000_00A2,   0,0, 6);
    add(0, BODY,     0, 32'h0,           1, 1, 0,0,0,0, 0, 32'h0,           0,0, 6);
    add(0, BODY,     0, 32'h0,           0, 1, 0,0,0,0, 0, 32'h0,           0,0, 6);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("reset_out", pk(out_valid, out_sop, out_eop, out_trunc, out_vc, out_data,
                        err_proto, err_route, pkt_cnt, 1'b1), 56'd0);
    chk("reset_frdy", {55'd0, flit_ready}, {55'd0, 1'b1});
    rst = 1'b0;
    @(negedge clk);

    foreach (vq[i]) begin
      step(vq[i], $sformatf("vec%0d", i));
    end

    // ---- reset mid-packet on vc1 ----
    t = vq[0];
    t.dat = H(2,3,24'hC); t.odat = H(2,3,24'hC); t.rdy = 1'b0; t.cnt = 16'd6;
    flit_valid = 1'b1; flit.label = HEAD; flit.vc_Id = 2'd1; flit.data = t.dat;
    out_ready  = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", {55'd0, out_valid}, {55'd0, 1'b1});
    rst = 1'b1;
    #1;
    chk("async_rst_out", pk(out_valid, out_sop, out_eop, out_trunc, out_vc, out_data,
                            err_proto, err_route, pkt_cnt, 1'b1), 56'd0);
    @(negedge clk);
    rst = 1'b0;
    t.v = 1; t.lab = BODY; t.vc = 1; t.dat = 32'h0000_0DDD; t.rdy = 1; t.frdy = 1;
    t.ov = 0; t.sop = 0; t.eop = 0; t.tr = 0; t.ovc = 0; t.odat = 0;
    t.ep = 1; t.er = 0; t.cnt = 0;
    step(t, "post_rst_body");

    // ---- counter wrap: 65536 back-to-back headtails ----
    flit_valid = 1'b1; flit.label = HEADTAIL; flit.vc_Id = 2'd0; flit.data = H(2,3,24'h5);
    out_ready  = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_all_ones", {40'd0, pkt_cnt}, {40'd0, 16'hFFFF});
    @(posedge clk);
    #1;
    chk("cnt_wrap", {40'd0, pkt_cnt}, {40'd0, 16'h0000});
    chk("wrap_word", pk(out_valid, out_sop, out_eop, out_trunc, out_vc, out_data,
                        err_proto, err_route, pkt_cnt, 1'b1),
        pk(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, H(2,3,24'h5), 1'b0, 1'b0, 16'h0, 1'b1));
    @(negedge clk);
    flit_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
